dmem_port_arbiter: RTL and testbench

Shares one single-ported data-memory access port between two requesters: the processor (load/store) and the VGA framebuffer fetch. The block sits between processor/topV and DataMemory in the calculator system. It replaces a dual-port memory with an arbitrated single port. Arbitration is round-robin, with a VGA-urgent override and a CPU anti-starvation bound.

---
 rtl/dmem_port_arbiter_pkg.sv | 7 +
 rtl/dmem_port_arbiter_if.sv | 38 +++
 rtl/dmem_port_arbiter_arb_pick.sv | 27 ++
 rtl/dmem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, grant owner, WAIT counter width.
// Optional statistics counters are enabled with the ARB_STATS_EN macro (see dmem_port_arbiter).
package dmem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
    typedef enum logic {GNT_CPU, GNT_VGA} grant_t;
    localparam int LAT_W = 2;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled for the CPU/VGA/DataMemory hookup.
// slave = arbiter view, master = environment view (requesters plus memory).
interface dmem_port_arbiter_if #(parameter int BUS = 32);
    logic           cpu_req;
    logic           cpu_we;
    logic [BUS-1:0] cpu_addr;
    logic [BUS-1:0] cpu_wdata;
    logic [BUS-1:0] cpu_rdata;
    logic           cpu_ack;
    logic           vga_req;
    logic           vga_urgent;
    logic [BUS-1:0] vga_addr;
    logic [BUS-1:0] vga_rdata;
    logic           vga_ack;
    logic [BUS-1:0] mem_addr;
    logic [BUS-1:0] mem_wdata;
    logic           mem_re;
    logic           mem_we;
    logic [BUS-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  vga_req, vga_urgent, vga_addr,
        output vga_rdata, vga_ack,
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output vga_req, vga_urgent, vga_addr,
        input  vga_rdata, vga_ack,
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter_arb_pick.sv
// Combinational winner selection: lone requester, anti-starvation, VGA urgency, then round-robin.
module arb_pick
    import dmem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   vga_req,
    input  logic   vga_urgent,
    input  logic   starve_hit,
    input  grant_t last_grant,
    output grant_t grant,
    output logic   any_req
);
    always_comb begin
        any_req = cpu_req | vga_req;
        grant   = GNT_CPU;
        if (vga_req && !cpu_req) begin
            grant = GNT_VGA;
        end else if (cpu_req && vga_req) begin
            if (starve_hit)
                grant = GNT_CPU;
            else if (vga_urgent)
                grant = GNT_VGA;
            else
                grant = (last_grant == GNT_CPU) ? GNT_VGA : GNT_CPU;
        end
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data-memory arbiter between CPU load/store and VGA framebuffer fetch.
// Define ARB_STATS_EN to add grant/conflict statistics outputs.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int BUS        = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arbiter_if.slave  bus_if
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]         stat_cpu_grants,
    output logic [31:0]         stat_vga_grants,
    output logic [31:0]         stat_conflicts
`endif
);
    localparam int               SC_W      = $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] WAIT_LOAD = LAT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    arb_state_t       r_state, w_state_nxt;
    grant_t           r_grant, r_last_grant, w_grant;
    logic             w_any_req, w_starve_hit, w_do_grant, w_do_done;
    logic [SC_W-1:0]  r_starve_cnt;
    logic [LAT_W-1:0] r_wait_cnt;
    logic             r_we;
    logic [BUS-1:0]   r_mem_addr, r_mem_wdata, r_cpu_rdata, r_vga_rdata;
    logic             r_mem_re, r_mem_we, r_cpu_ack, r_vga_ack;

    assign w_starve_hit = (r_starve_cnt >= SC_W'(STARVE_MAX));

    arb_pick u_pick (
        .cpu_req    (bus_if.cpu_req),
        .vga_req    (bus_if.vga_req),
        .vga_urgent (bus_if.vga_urgent),
        .starve_hit (w_starve_hit),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .any_req    (w_any_req)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_grant  = 1'b0;
        w_do_done   = 1'b0;
        case (r_state)
            IDLE: if (w_any_req) begin
                w_state_nxt = ISSUE;
                w_do_grant  = 1'b1;
            end
            ISSUE: if (MEM_LAT > 1) begin
                w_state_nxt = WAIT;
            end else begin
                w_state_nxt = DONE;
                w_do_done   = 1'b1;
            end
            WAIT: if (r_wait_cnt == '0) begin
                w_state_nxt = DONE;
                w_do_done   = 1'b1;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are loaded on the edge entering the state that shows them, so
    // strobes appear in ISSUE and ack/rdata appear together in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant      <= GNT_CPU;
            r_last_grant <= GNT_VGA;
            r_starve_cnt <= '0;
            r_wait_cnt   <= '0;
            r_we         <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_cpu_rdata  <= '0;
            r_vga_rdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_vga_ack    <= 1'b0;
        end else begin
            r_mem_re  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_vga_ack <= 1'b0;

            if (r_state == ISSUE) begin
                r_mem_addr  <= '0;
                r_mem_wdata <= '0;
                r_wait_cnt  <= WAIT_LOAD;
            end else if (r_state == WAIT && r_wait_cnt != '0) begin
                r_wait_cnt  <= r_wait_cnt - LAT_W'(1);
            end

            if (w_do_grant) begin
                r_grant      <= w_grant;
                r_last_grant <= w_grant;
                if (w_grant == GNT_CPU) begin
                    r_we        <= bus_if.cpu_we;
                    r_mem_addr  <= bus_if.cpu_addr;
                    r_mem_wdata <= bus_if.cpu_wdata;
                    r_mem_re    <= !bus_if.cpu_we;
                    r_mem_we    <= bus_if.cpu_we;
                end else begin
                    r_we        <= 1'b0;
                    r_mem_addr  <= bus_if.vga_addr;
                    r_mem_wdata <= '0;
                    r_mem_re    <= 1'b1;
                end
            end

            if (r_state == IDLE) begin
                if (!bus_if.cpu_req)
                    r_starve_cnt <= '0;
                else if (w_do_grant && w_grant == GNT_CPU)
                    r_starve_cnt <= '0;
                else if (w_do_grant && !w_starve_hit)
                    r_starve_cnt <= r_starve_cnt + SC_W'(1);
            end

            if (w_do_done) begin
                if (r_grant == GNT_CPU) begin
                    r_cpu_ack <= 1'b1;
                    if (!r_we) r_cpu_rdata <= bus_if.mem_rdata;
                end else begin
                    r_vga_ack   <= 1'b1;
                    r_vga_rdata <= bus_if.mem_rdata;
                end
            end
        end
    end

    assign bus_if.mem_addr  = r_mem_addr;
    assign bus_if.mem_wdata = r_mem_wdata;
    assign bus_if.mem_re    = r_mem_re;
    assign bus_if.mem_we    = r_mem_we;
    assign bus_if.cpu_rdata = r_cpu_rdata;
    assign bus_if.cpu_ack   = r_cpu_ack;
    assign bus_if.vga_rdata = r_vga_rdata;
    assign bus_if.vga_ack   = r_vga_ack;

`ifdef ARB_STATS_EN
    logic [31:0] r_stat_cpu, r_stat_vga, r_stat_conf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_cpu  <= '0;
            r_stat_vga  <= '0;
            r_stat_conf <= '0;
        end else if (w_do_grant) begin
            if (w_grant == GNT_CPU) r_stat_cpu <= r_stat_cpu + 32'd1;
            else                    r_stat_vga <= r_stat_vga + 32'd1;
            if (bus_if.cpu_req && bus_if.vga_req)
                r_stat_conf <= r_stat_conf + 32'd1;
        end
    end

    assign stat_cpu_grants = r_stat_cpu;
    assign stat_vga_grants = r_stat_vga;
    assign stat_conflicts  = r_stat_conf;
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
// Stimulus pushes expected acks into per-instance queues; negedge monitors pop and compare.
module tb_dmem_port_arbiter;
    localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

    typedef struct packed {
        logic        is_cpu;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q1[$];
    exp_t q3[$];

    dmem_port_arbiter_if #(.BUS(32)) b1 ();
    dmem_port_arbiter_if #(.BUS(32)) b3 ();

`ifdef ARB_STATS_EN
    logic [31:0] s1_cpu, s1_vga, s1_conf, s3_cpu, s3_vga, s3_conf;
`endif

    dmem_port_arbiter #(.BUS(32), .MEM_LAT(1), .STARVE_MAX(8)) u_dut1 (
        .clk    (clk),
        .reset  (reset),
        .bus_if (b1)
`ifdef ARB_STATS_EN
        ,
        .stat_cpu_grants (s1_cpu),
        .stat_vga_grants (s1_vga),
        .stat_conflicts  (s1_conf)
`endif
    );

    dmem_port_arbiter #(.BUS(32), .MEM_LAT(3), .STARVE_MAX(8)) u_dut3 (
        .clk    (clk),
        .reset  (reset),
        .bus_if (b3)
`ifdef ARB_STATS_EN
        ,
        .stat_cpu_grants (s3_cpu),
        .stat_vga_grants (s3_vga),
        .stat_conflicts  (s3_conf)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | a);
    endfunction

    // Memory models: data is presented only for the edge that ends the
    // MEM_LAT-th cycle after the strobe; garbage otherwise.
    int          c1 = -1, c3 = -1;
    logic [31:0] a1 = '0, a3 = '0;
    always @(negedge clk) begin
        if (b1.mem_re) begin a1 = b1.mem_addr; c1 = 0; end
        else if (c1 > 0) c1--;
        else c1 = -1;
        b1.mem_rdata = (c1 == 0) ? mem_f(a1) : GARBAGE;
    end
    always @(negedge clk) begin
        if (b3.mem_re) begin a3 = b3.mem_addr; c3 = 2; end
        else if (c3 > 0) c3--;
        else c3 = -1;
        b3.mem_rdata = (c3 == 0) ? mem_f(a3) : GARBAGE;
    end

    task automatic score(input string tag, input logic c_ack, input logic v_ack,
                         input logic [31:0] c_rd, input logic [31:0] v_rd,
                         input logic have, input exp_t e);
        if (!have) begin
            chk({tag, "_unexpected_ack"}, {30'd0, c_ack, v_ack}, 32'd0);
        end else begin
            chk({tag, "_ack_owner"}, {30'd0, c_ack, v_ack}, e.is_cpu ? 32'd2 : 32'd1);
            if (e.chk_data) chk({tag, "_rdata"}, e.is_cpu ? c_rd : v_rd, e.data);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic have;
        if (reset === 1'b1 && (b1.cpu_ack || b1.vga_ack)) begin
            have = (q1.size() != 0);
            e    = have ? q1.pop_front() : '0;
            score("d1", b1.cpu_ack, b1.vga_ack, b1.cpu_rdata, b1.vga_rdata, have, e);
        end
    end
    always @(negedge clk) begin
        exp_t e;
        logic have;
        if (reset === 1'b1 && (b3.cpu_ack || b3.vga_ack)) begin
            have = (q3.size() != 0);
            e    = have ? q3.pop_front() : '0;
            score("d3", b3.cpu_ack, b3.vga_ack, b3.cpu_rdata, b3.vga_rdata, have, e);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_d1_ctl"}, {28'd0, b1.mem_re, b1.mem_we, b1.cpu_ack, b1.vga_ack}, 32'd0);
        chk({tag, "_d1_addr"}, b1.mem_addr | b1.mem_wdata, 32'd0);
        chk({tag, "_d1_rdata"}, b1.cpu_rdata | b1.vga_rdata, 32'd0);
        chk({tag, "_d3_ctl"}, {28'd0, b3.mem_re, b3.mem_we, b3.cpu_ack, b3.vga_ack}, 32'd0);
        chk({tag, "_d3_addr"}, b3.mem_addr | b3.mem_wdata, 32'd0);
        chk({tag, "_d3_rdata"}, b3.cpu_rdata | b3.vga_rdata, 32'd0);
    endtask

    task automatic cpu1_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic seen = 1'b0;
        b1.cpu_we = we; b1.cpu_addr = addr; b1.cpu_wdata = wdata; b1.cpu_req = 1'b1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("cpu_strobe", {30'd0, b1.mem_re, b1.mem_we}, we ? 32'd1 : 32'd2);
                chk("cpu_mem_addr", b1.mem_addr, addr);
                if (we) chk("cpu_mem_wdata", b1.mem_wdata, wdata);
            end
            if (k == 2) chk("strobe_one_cycle", {30'd0, b1.mem_re, b1.mem_we}, 32'd0);
            if (b1.cpu_ack) begin
                seen = 1'b1;
                chk("cpu_latency", 32'(k), 32'd2);
            end
        end
        if (!seen) chk("cpu_ack_timeout", 32'd0, 32'd1);
        b1.cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic both1(input logic urgent, input int n);
        int acks = 0;
        int last_k = 0;
        b1.cpu_we = 1'b0; b1.cpu_addr = 32'h30; b1.vga_addr = 32'h200;
        b1.vga_urgent = urgent; b1.cpu_req = 1'b1; b1.vga_req = 1'b1;
        for (int k = 1; k <= 100 && acks < n; k++) begin
            @(negedge clk);
            if (b1.cpu_ack || b1.vga_ack) begin
                acks++;
                chk("ack_spacing", 32'(k - last_k), (acks == 1) ? 32'd2 : 32'd3);
                last_k = k;
            end
        end
        if (acks != n) chk("both_ack_timeout", 32'(acks), 32'(n));
        b1.cpu_req = 1'b0; b1.vga_req = 1'b0; b1.vga_urgent = 1'b0;
        @(negedge clk);
    endtask

    localparam exp_t E_CPU30  = '{1'b1, 1'b1, 32'hC0DE_0030};
    localparam exp_t E_VGA200 = '{1'b0, 1'b1, 32'hC0DE_0200};

    initial begin
        logic seen;
        int   acks;
        reset = 1'b0;
        b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
        b1.vga_req = 0; b1.vga_urgent = 0; b1.vga_addr = '0;
        b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
        b3.vga_req = 0; b3.vga_urgent = 0; b3.vga_addr = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // Round-robin, CPU first after reset.
        q1.push_back(E_CPU30);  q1.push_back(E_VGA200);
        q1.push_back(E_CPU30);  q1.push_back(E_VGA200);
        both1(1'b0, 4);

        // Lone read, then a write that must leave cpu_rdata alone.
        q1.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF});
        cpu1_txn(1'b0, 32'h10, 32'h0);
        q1.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF});
        cpu1_txn(1'b1, 32'h20, 32'h55);

        // Urgent VGA: eight VGA grants, starvation bound hands one to CPU.
        for (int i = 0; i < 8; i++) q1.push_back(E_VGA200);
        q1.push_back(E_CPU30);
        q1.push_back(E_VGA200);
        both1(1'b1, 10);

        // MEM_LAT=3 VGA read; model shows garbage before the capture edge.
        q3.push_back('{1'b0, 1'b1, 32'hC0DE_0100});
        b3.vga_addr = 32'h100; b3.vga_req = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("lat3_strobe", {31'd0, b3.mem_re}, 32'd1);
                chk("lat3_mem_addr", b3.mem_addr, 32'h100);
            end
            if (b3.vga_ack) begin
                seen = 1'b1;
                chk("lat3_latency", 32'(k), 32'd4);
            end
        end
        if (!seen) chk("lat3_ack_timeout", 32'd0, 32'd1);
        b3.vga_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in WAIT drops the transaction; the tie re-arbitrates to CPU.
        b3.cpu_we = 1'b0; b3.cpu_addr = 32'h40; b3.vga_addr = 32'h140;
        b3.cpu_req = 1'b1; b3.vga_req = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_zero("mid_wait_reset");
        @(negedge clk);
        reset = 1'b1;
        q3.push_back('{1'b1, 1'b1, 32'hC0DE_0040});
        q3.push_back('{1'b0, 1'b1, 32'hC0DE_0140});
        acks = 0;
        for (int k = 1; k <= 40 && acks < 2; k++) begin
            @(negedge clk);
            if (b3.cpu_ack) begin b3.cpu_req = 1'b0; acks++; end
            if (b3.vga_ack) begin b3.vga_req = 1'b0; acks++; end
        end
        if (acks != 2) chk("rearb_ack_timeout", 32'(acks), 32'd2);
        b3.cpu_req = 1'b0; b3.vga_req = 1'b0;

        repeat (8) @(negedge clk);
        chk("d1_queue_drained", 32'(q1.size()), 32'd0);
        chk("d3_queue_drained", 32'(q3.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
